psdsqrt_iter: RTL and testbench

Parametrised, multiplier-free iterative integer square root with a start/busy/done handshake. It computes floor(sqrt(xin)) digit by digit using restoring shift-subtract. Each clock resolves STEPS root bits, so area trades against latency. It is the successor of the existing pseudo-square-root unit in the sqrt datapath and drops in wherever a bounded-latency, self-timed root is needed.

---
 rtl/psdsqrt_pkg.sv | 31 +++
 rtl/psdsqrt_step.sv | 31 +++
 rtl/psdsqrt_iter.sv | 137 +++++++++++++
 tb/tb_psdsqrt_iter.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/psdsqrt_pkg.sv
// Shared definitions for the iterative square-root unit: FSM state encoding,
// counter-width helper and the parameter-legality check used at elaboration.
package psdsqrt_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } psdsqrt_state_e;

    // Ceiling log2, minimum 1, for sizing counters at elaboration time.
    function automatic int clog2_fn(input int value);
        int width;
        width = 1;
        for (int i = 1; i < 31; i++) begin
            if ((32'sd1 <<< i) < value) begin
                width = i + 1;
            end else begin
                width = width;
            end
        end
        return width;
    endfunction

    // NBITS must be even and at least 4; STEPS must evenly divide NBITS/2.
    function automatic bit steps_valid(input int nbits, input int steps);
        return (nbits >= 4) && ((nbits % 2) == 0) && (steps >= 1) &&
               (((nbits / 2) % steps) == 0);
    endfunction

endpackage

// File: rtl/psdsqrt_step.sv
// One restoring shift-subtract digit step of the integer square root.
// The remainder carries two extra bits: one for growth, one as the trial sign.
module psdsqrt_step
    import psdsqrt_pkg::*;
#(
    parameter int HW = 16
) (
    input  logic [HW+1:0] rem_i,
    input  logic [HW-1:0] root_i,
    input  logic [1:0]    bits_i,
    output logic [HW+1:0] rem_o,
    output logic [HW-1:0] root_o
);

    logic [HW+1:0] shifted_s;
    logic [HW+1:0] trial_s;

    // Bring in two radicand bits, try subtracting {root,01}, keep if non-negative.
    always_comb begin
        shifted_s = {rem_i[HW-1:0], bits_i};
        trial_s   = shifted_s - {root_i, 2'b01};
        if (trial_s[HW+1] == 1'b0) begin
            rem_o  = trial_s;
            root_o = {root_i[HW-2:0], 1'b1};
        end else begin
            rem_o  = shifted_s;
            root_o = {root_i[HW-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/psdsqrt_iter.sv
// Iterative multiplier-free integer square root, STEPS root bits per clock,
// with a start/busy/done handshake. Define PSDSQRT_REM_EN to expose the
// final remainder on the rem port; otherwise the remainder stays internal.
module psdsqrt_iter
    import psdsqrt_pkg::*;
#(
    parameter int NBITS = 32,
    parameter int STEPS = 1
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic [NBITS-1:0]   xin,
    output logic               busy,
    output logic               done,
    output logic [NBITS/2-1:0] sqrt
`ifdef PSDSQRT_REM_EN
    ,
    output logic [NBITS/2:0]   rem
`endif
);

    localparam int HW    = NBITS / 2;
    localparam int RW    = HW + 2;
    localparam int ITERS = HW / STEPS;
    localparam int SHIFT = 2 * STEPS;
    localparam int CW    = clog2_fn(ITERS + 1);
    localparam logic [CW-1:0] CNT_LOAD = CW'(ITERS);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    if (!steps_valid(NBITS, STEPS)) begin : g_bad_cfg
        $error("psdsqrt_iter: NBITS must be even >= 4 and STEPS must divide NBITS/2");
    end

    psdsqrt_state_e state_q, state_d;
    logic [NBITS-1:0] x_q, x_d;
    logic [HW-1:0]    root_q, root_d;
    logic [RW-1:0]    rem_q, rem_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [HW-1:0]    sqrt_q, sqrt_d;
`ifdef PSDSQRT_REM_EN
    logic [HW:0]      remo_q, remo_d;
`endif

    logic [RW-1:0] rem_c  [0:STEPS];
    logic [HW-1:0] root_c [0:STEPS];

    assign rem_c[0]  = rem_q;
    assign root_c[0] = root_q;

    for (genvar s = 0; s < STEPS; s++) begin : g_step
        psdsqrt_step #(.HW(HW)) u_step (
            .rem_i  (rem_c[s]),
            .root_i (root_c[s]),
            .bits_i (x_q[NBITS-1-2*s -: 2]),
            .rem_o  (rem_c[s+1]),
            .root_o (root_c[s+1])
        );
    end

    // Next-state and datapath update for the IDLE/RUN/DONE sequencer.
    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        root_d  = root_q;
        rem_d   = rem_q;
        cnt_d   = cnt_q;
        sqrt_d  = sqrt_q;
`ifdef PSDSQRT_REM_EN
        remo_d  = remo_q;
`endif
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    x_d     = xin;
                    root_d  = {HW{1'b0}};
                    rem_d   = {RW{1'b0}};
                    cnt_d   = CNT_LOAD;
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                x_d    = x_q << SHIFT;
                root_d = root_c[STEPS];
                rem_d  = rem_c[STEPS];
                cnt_d  = cnt_q - CNT_ONE;
                if (cnt_q == CNT_ONE) begin
                    sqrt_d  = root_c[STEPS];
`ifdef PSDSQRT_REM_EN
                    remo_d  = rem_c[STEPS][HW:0];
`endif
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous active-high reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
            x_q     <= {NBITS{1'b0}};
            root_q  <= {HW{1'b0}};
            rem_q   <= {RW{1'b0}};
            cnt_q   <= {CW{1'b0}};
            sqrt_q  <= {HW{1'b0}};
`ifdef PSDSQRT_REM_EN
            remo_q  <= {(HW+1){1'b0}};
`endif
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            root_q  <= root_d;
            rem_q   <= rem_d;
            cnt_q   <= cnt_d;
            sqrt_q  <= sqrt_d;
`ifdef PSDSQRT_REM_EN
            remo_q  <= remo_d;
`endif
        end
    end

    assign busy = (state_q == ST_RUN);
    assign done = (state_q == ST_DONE);
    assign sqrt = sqrt_q;
`ifdef PSDSQRT_REM_EN
    assign rem  = remo_q;
`endif

endmodule

// File: tb/tb_psdsqrt_iter.sv
// Directed bench for psdsqrt_iter: one instance with STEPS=1 and one with
// STEPS=4 (checked against an independent binary-search square root).
module tb_psdsqrt_iter;

    logic        clock = 1'b0;
    logic        reset;
    logic        start1, start4;
    logic [31:0] xin1, xin4;
    logic        busy1, done1, busy4, done4;
    logic [15:0] sqrt1, sqrt4;
`ifdef PSDSQRT_REM_EN
    logic [16:0] rem1, rem4;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clock = ~clock;

    psdsqrt_iter #(.NBITS(32), .STEPS(1)) u_dut1 (
        .clock (clock),
        .reset (reset),
        .start (start1),
        .xin   (xin1),
        .busy  (busy1),
        .done  (done1),
        .sqrt  (sqrt1)
`ifdef PSDSQRT_REM_EN
        ,
        .rem   (rem1)
`endif
    );

    psdsqrt_iter #(.NBITS(32), .STEPS(4)) u_dut4 (
        .clock (clock),
        .reset (reset),
        .start (start4),
        .xin   (xin4),
        .busy  (busy4),
        .done  (done4),
        .sqrt  (sqrt4)
`ifdef PSDSQRT_REM_EN
        ,
        .rem   (rem4)
`endif
    );

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: bitwise binary search on the root, using multiplication.
    function automatic logic [15:0] ref_sqrt(input logic [31:0] x);
        logic [63:0] r;
        logic [63:0] t;
        r = 64'd0;
        for (int b = 15; b >= 0; b--) begin
            t = r | (64'd1 << b);
            if (t * t <= {32'd0, x}) r = t;
        end
        return r[15:0];
    endfunction

    task automatic wait_done1(output int cycles);
        cycles = 0;
        do begin
            @(posedge clock); #1;
            cycles++;
        end while (!done1 && cycles < 40);
    endtask

    task automatic wait_done4(output int cycles);
        cycles = 0;
        do begin
            @(posedge clock); #1;
            cycles++;
        end while (!done4 && cycles < 20);
    endtask

    task automatic run1(input logic [31:0] x, input logic [15:0] es, input logic [16:0] er,
                        input string tag);
        int cyc;
        @(negedge clock);
        xin1 = x; start1 = 1'b1;
        @(posedge clock); #1;
        start1 = 1'b0;
        check_val({tag, "_busy"}, {63'd0, busy1}, 64'd1);
        wait_done1(cyc);
        check_val({tag, "_lat"}, cyc, 64'd16);
        check_val({tag, "_sqrt"}, sqrt1, {48'd0, es});
`ifdef PSDSQRT_REM_EN
        check_val({tag, "_rem"}, rem1, {47'd0, er});
`endif
    endtask

    task automatic run4(input logic [31:0] x, input string tag);
        int cyc;
        logic [15:0] es;
        logic [63:0] er;
        es = ref_sqrt(x);
        er = {32'd0, x} - {48'd0, es} * {48'd0, es};
        @(negedge clock);
        xin4 = x; start4 = 1'b1;
        @(posedge clock); #1;
        start4 = 1'b0;
        wait_done4(cyc);
        check_val({tag, "_lat"}, cyc, 64'd4);
        check_val({tag, "_sqrt"}, sqrt4, {48'd0, es});
`ifdef PSDSQRT_REM_EN
        check_val({tag, "_rem"}, rem4, er);
`endif
    endtask

    initial begin
        int cyc;
        reset = 1'b1; start1 = 1'b0; start4 = 1'b0; xin1 = 32'd0; xin4 = 32'd0;
        repeat (3) @(posedge clock);
        #1;
        check_val("rst_busy1", {63'd0, busy1}, 64'd0);
        check_val("rst_done1", {63'd0, done1}, 64'd0);
        check_val("rst_sqrt1", sqrt1, 64'd0);
        check_val("rst_busy4", {63'd0, busy4}, 64'd0);
        check_val("rst_done4", {63'd0, done4}, 64'd0);
`ifdef PSDSQRT_REM_EN
        check_val("rst_rem1", rem1, 64'd0);
`endif
        @(negedge clock);
        reset = 1'b0;

        // Directed values.
        run1(32'd0,          16'd0,      17'd0,       "x0");
        run1(32'hFFFF_FFFF,  16'hFFFF,   17'h1FFFE,   "xmax");
        run1(32'd17,         16'd4,      17'd1,       "x17");
        run1(32'd1000000,    16'd1000,   17'd0,       "x1e6");

        // start mid-RUN with a different radicand is ignored.
        @(negedge clock);
        xin1 = 32'hFFFF_FFFF; start1 = 1'b1;
        @(posedge clock); #1;
        start1 = 1'b0;
        repeat (4) @(posedge clock);
        @(negedge clock);
        start1 = 1'b1; xin1 = 32'd17;
        @(posedge clock); #1;
        check_val("ign_busy", {63'd0, busy1}, 64'd1);
        start1 = 1'b0;
        wait_done1(cyc);
        check_val("ign_lat", cyc, 64'd11);
        check_val("ign_sqrt", sqrt1, 64'hFFFF);
`ifdef PSDSQRT_REM_EN
        check_val("ign_rem", rem1, 64'h1FFFE);
`endif

        // Reset in the middle of a computation.
        @(negedge clock);
        xin1 = 32'd1000000; start1 = 1'b1;
        @(posedge clock); #1;
        start1 = 1'b0;
        repeat (6) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock); #1;
        check_val("mrst_busy", {63'd0, busy1}, 64'd0);
        check_val("mrst_done", {63'd0, done1}, 64'd0);
        check_val("mrst_sqrt", sqrt1, 64'd0);
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock); #1;
        check_val("mrst_idle", {63'd0, busy1}, 64'd0);
        run1(32'd17, 16'd4, 17'd1, "post_rst");

        // Back-to-back with start held through the done cycle.
        @(negedge clock);
        xin1 = 32'd144; start1 = 1'b1;
        @(posedge clock); #1;
        xin1 = 32'd145;
        wait_done1(cyc);
        check_val("b2b_lat0", cyc, 64'd16);
        check_val("b2b_sqrt0", sqrt1, 64'd12);
`ifdef PSDSQRT_REM_EN
        check_val("b2b_rem0", rem1, 64'd0);
`endif
        wait_done1(cyc);
        start1 = 1'b0;
        check_val("b2b_gap", cyc, 64'd17);
        check_val("b2b_sqrt1", sqrt1, 64'd12);
`ifdef PSDSQRT_REM_EN
        check_val("b2b_rem1", rem1, 64'd1);
`endif
        @(posedge clock); #1;
        check_val("b2b_idle_done", {63'd0, done1}, 64'd0);
        check_val("b2b_idle_busy", {63'd0, busy1}, 64'd0);
        check_val("b2b_hold", sqrt1, 64'd12);

        // STEPS=4 instance: edge values then random radicands.
        run4(32'd0,         "s4_zero");
        run4(32'hFFFF_FFFF, "s4_max");
        run4(32'd1,         "s4_one");
        run4(32'd3,         "s4_three");
        run4(32'h8000_0000, "s4_half");
        run4(32'hFFFE_0001, "s4_sq");
        for (int i = 0; i < 1000; i++) begin
            run4($urandom, "s4_rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
